dbus_sram_responder: RTL and testbench

Responder end of the core's data bus, the counterpart of the memory stage's IDLE/WAITING/OVER request initiator. Accepts one load/store request at a time, serves it from an internal doubleword-addressed SRAM after a fixed latency, and signals completion with addr_ok/data_ok. Used as the simulation-side data memory behind the memory stage and as a reusable bus endpoint for stage-level benches.

---
 rtl/dbus_sram_responder_pkg.sv | 43 ++++
 rtl/dbus_sram_responder_if.sv | 10 +
 rtl/dbus_sram_responder_array.sv | 27 ++
 rtl/dbus_sram_responder.sv | 103 ++++++++++
 tb/tb_dbus_sram_responder.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/dbus_sram_responder_pkg.sv
// Shared types for the data-bus responder: request/response structs, FSM states,
// access-size encoding and the natural-alignment helper.
package dbus_sram_responder_pkg;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_WAIT = 2'd1,
        D_RESP = 2'd2
    } dbus_resp_state_t;

    // size stays a raw 3-bit field so illegal encodings reach the responder's check
    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    function automatic logic is_aligned(input logic [2:0] addr_lo, input logic [2:0] size);
        case (msize_t'(size))
            MSIZE1:  return 1'b1;
            MSIZE2:  return addr_lo[0] == 1'b0;
            MSIZE4:  return addr_lo[1:0] == 2'b00;
            MSIZE8:  return addr_lo == 3'b000;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dbus_sram_responder_if.sv
// Data-bus request/response bundle; the initiator drives req, the responder drives resp.
interface dbus_sram_responder_if;
    import dbus_sram_responder_pkg::*;

    dbus_req_t  req;
    dbus_resp_t resp;

    modport master (output req, input resp);
    modport slave  (input req, output resp);
endinterface

// File: rtl/dbus_sram_responder_array.sv
// DEPTH_WORDS x 64 single-port SRAM: combinational read, per-byte-enabled write on clk.
module dbus_sram_array #(
    parameter  int DEPTH_WORDS = 1024,
    localparam int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [7:0]    i_be,
    input  logic [AW-1:0] i_addr,
    input  logic [63:0]   i_wdata,
    output logic [63:0]   o_rdata
);

    // One byte-wide array per lane keeps each lane a plain single-writer memory
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
        logic [7:0] r_mem [DEPTH_WORDS];

        always_ff @(posedge i_clk) begin
            if (i_we && i_be[gi]) begin
                r_mem[i_addr] <= i_wdata[gi*8 +: 8];
            end
        end

        assign o_rdata[gi*8 +: 8] = r_mem[i_addr];
    end

endmodule

// File: rtl/dbus_sram_responder.sv
// Single-outstanding data-bus responder: latches a request, waits LATENCY cycles,
// then answers from the internal SRAM with a one-cycle addr_ok/data_ok pulse.
module dbus_sram_responder
    import dbus_sram_responder_pkg::*;
#(
    parameter int          LATENCY     = 2,
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [63:0] BASE_ADDR   = 64'h8000_0000
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    dbus_sram_responder_if.slave   io_dbus,
    output logic                   o_busy,
    output logic                   o_oor_seen
);

    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [63:0] SPAN     = 64'(DEPTH_WORDS) * 64'd8;
    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

    dbus_resp_state_t r_state;
    dbus_resp_state_t w_state_next;
    logic [3:0]       r_cnt;
    logic [AW-1:0]    r_idx;
    logic [7:0]       r_strobe;
    logic [63:0]      r_data;
    logic             r_bad;
    logic             r_oor_seen;

    logic [63:0]      w_offset;
    logic             w_bad;
    logic             w_accept;
    logic             w_resp;
    logic             w_we;
    logic [63:0]      w_rdata;

    // Offset is unsigned; addresses below the base are caught by the explicit compare
    assign w_offset = io_dbus.req.addr - BASE_ADDR;
    assign w_bad    = (io_dbus.req.addr < BASE_ADDR) || (w_offset >= SPAN) ||
                      !is_aligned(io_dbus.req.addr[2:0], io_dbus.req.size);
    assign w_accept = (r_state == D_IDLE) && io_dbus.req.valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= D_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            D_IDLE: if (io_dbus.req.valid) w_state_next = (LATENCY == 1) ? D_RESP : D_WAIT;
            D_WAIT: if (r_cnt == 4'd1) w_state_next = D_RESP;
            D_RESP: w_state_next = D_IDLE;
            default: w_state_next = D_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt      <= '0;
            r_idx      <= '0;
            r_strobe   <= '0;
            r_data     <= '0;
            r_bad      <= 1'b0;
            r_oor_seen <= 1'b0;
        end else if (w_accept) begin
            r_cnt      <= CNT_LOAD;
            r_idx      <= w_offset[AW+2:3];
            r_strobe   <= io_dbus.req.strobe;
            r_data     <= io_dbus.req.data;
            r_bad      <= w_bad;
            r_oor_seen <= r_oor_seen | w_bad;
        end else if (r_state == D_WAIT) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    always_comb begin
        io_dbus.resp         = '0;
        w_resp               = (r_state == D_RESP);
        io_dbus.resp.addr_ok = w_resp;
        io_dbus.resp.data_ok = w_resp;
        io_dbus.resp.data    = (w_resp && !r_bad) ? w_rdata : 64'd0;
        w_we                 = w_resp && !r_bad && (r_strobe != 8'd0);
        o_busy               = (r_state != D_IDLE);
        o_oor_seen           = r_oor_seen;
    end

    dbus_sram_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_be    (r_strobe),
        .i_addr  (r_idx),
        .i_wdata (r_data),
        .o_rdata (w_rdata)
    );

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Bench for dbus_sram_responder: directed bus scenarios plus randomized traffic
// checked against a word-array reference model of the responder's memory.
module tb_dbus_sram_responder;
    import dbus_sram_responder_pkg::*;

    localparam logic [63:0] BASE    = 64'h8000_0000;
    localparam int          DEPTH_A = 1024;
    localparam int          LAT_A   = 2;
    localparam int          WIN     = 40;

    logic clk = 1'b0;
    logic rst_n;
    logic busy_a, oor_a, busy_b, oor_b;

    dbus_sram_responder_if bus_a ();
    dbus_sram_responder_if bus_b ();

    dbus_sram_responder #(.LATENCY(LAT_A), .DEPTH_WORDS(DEPTH_A), .BASE_ADDR(BASE)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .io_dbus(bus_a), .o_busy(busy_a), .o_oor_seen(oor_a));

    dbus_sram_responder #(.LATENCY(1), .DEPTH_WORDS(16), .BASE_ADDR(BASE)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .io_dbus(bus_b), .o_busy(busy_b), .o_oor_seen(oor_b));

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] model_mem [WIN];
    bit          known [WIN];
    bit          exp_oor = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit addr_bad(input logic [63:0] a, input logic [2:0] sz);
        if (sz > 3'd3) return 1'b1;
        if (a < BASE || a >= BASE + 64'd8 * 64'(DEPTH_A)) return 1'b1;
        return (a & ((64'd1 << sz) - 64'd1)) != 64'd0;
    endfunction

    // One request on dut_a; mutate scrambles the request fields one cycle after accept
    task automatic xact(input logic [63:0] addr, input logic [2:0] sz, input logic [7:0] strb,
                        input logic [63:0] wd, input bit mutate, output logic [63:0] rdata);
        bit          bad;
        int          idx;
        int          lat;
        logic [63:0] exp_data;
        bad      = addr_bad(addr, sz);
        idx      = 0;
        exp_data = 64'd0;
        if (!bad) begin
            idx      = int'((addr - BASE) >> 3);
            exp_data = model_mem[idx];
        end
        rdata = 64'd0;
        @(negedge clk);
        bus_a.req.valid  = 1'b1;
        bus_a.req.addr   = addr;
        bus_a.req.size   = sz;
        bus_a.req.strobe = strb;
        bus_a.req.data   = wd;
        @(posedge clk);
        if (bad) exp_oor = 1'b1;
        lat = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge clk);
            if (mutate && k == 1) begin
                bus_a.req.addr   = 64'h8000_0100;
                bus_a.req.data   = ~wd;
                bus_a.req.strobe = 8'hFF;
                bus_a.req.size   = 3'd3;
            end
            check("busy", busy_a, 1);
            check("data_ok", bus_a.resp.data_ok, k == LAT_A);
            check("addr_ok", bus_a.resp.addr_ok, k == LAT_A);
            if (bus_a.resp.data_ok) begin
                lat   = k;
                rdata = bus_a.resp.data;
                if (bad || known[idx]) check("rdata", bus_a.resp.data, exp_data);
                bus_a.req.valid = 1'b0;
            end else begin
                check("data_idle", bus_a.resp.data, 0);
            end
        end
        bus_a.req.valid = 1'b0;
        check("latency", lat, LAT_A);
        @(negedge clk);
        check("busy_post", busy_a, 0);
        check("oor", oor_a, exp_oor);
        if (!bad && strb != 8'd0) begin
            for (int b = 0; b < 8; b++) begin
                if (strb[b]) model_mem[idx][b*8 +: 8] = wd[b*8 +: 8];
            end
            if (strb == 8'hFF) known[idx] = 1'b1;
        end
        $display("XACT addr=%h size=%0d strobe=%h wdata=%h rdata=%h lat=%0d bad=%0d",
                 addr, sz, strb, wd, rdata, lat, bad);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_data_ok"}, bus_a.resp.data_ok, 0);
        check({tag, "_addr_ok"}, bus_a.resp.addr_ok, 0);
        check({tag, "_data"}, bus_a.resp.data, 0);
        check({tag, "_busy"}, busy_a, 0);
        check({tag, "_oor"}, oor_a, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] rd;
        logic [63:0] d1;
        logic [63:0] a;
        logic [2:0]  sz;
        logic [7:0]  strb;
        int          off;
        bus_a.req = '0;
        bus_b.req = '0;
        for (int w = 0; w < WIN; w++) known[w] = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_quiet("reset");
        check("reset_b_busy", busy_b, 0);
        check("reset_b_data_ok", bus_b.resp.data_ok, 0);
        rst_n = 1'b1;

        for (int w = 0; w < WIN; w++) begin
            xact(BASE + 64'(w) * 64'd8, 3'd3, 8'hFF, {$urandom, $urandom}, 1'b0, rd);
        end

        xact(64'h8000_0008, 3'd3, 8'hFF, 64'h1122334455667788, 1'b0, rd);
        xact(64'h8000_0008, 3'd3, 8'h00, 64'd0, 1'b0, rd);
        check("sd_ld", rd, 64'h1122334455667788);
        xact(64'h8000_0009, 3'd0, 8'h02, 64'h0000_0000_0000_AB00, 1'b0, rd);
        xact(64'h8000_0008, 3'd3, 8'h00, 64'd0, 1'b0, rd);
        check("sb_ld", rd, 64'h112233445566AB88);

        xact(64'h7FFF_FFF8, 3'd3, 8'h00, 64'd0, 1'b0, rd);
        check("oor_low_data", rd, 0);
        xact(64'h8000_0002, 3'd2, 8'h00, 64'd0, 1'b0, rd);
        check("misalign_data", rd, 0);
        xact(BASE + 64'd8 * 64'(DEPTH_A), 3'd3, 8'hFF, 64'h55, 1'b0, rd);
        check("oor_high_data", rd, 0);
        xact(64'h8000_0008, 3'd3, 8'h00, 64'd0, 1'b0, rd);
        check("after_oor_ld", rd, 64'h112233445566AB88);

        for (int n = 0; n < 60; n++) begin
            sz  = 3'($urandom_range(0, 3));
            off = $urandom_range(0, 7) & ~((1 << sz) - 1);
            a   = BASE + 64'($urandom_range(0, WIN - 1)) * 64'd8 + 64'(off);
            case ($urandom_range(0, 15))
                0: a = BASE - 64'd8;
                1: if (sz != 3'd0) a = a | 64'd1;
                2: sz = 3'($urandom_range(4, 7));
                default: ;
            endcase
            strb = 8'h00;
            if ($urandom_range(0, 1) == 1) strb = 8'(((1 << (1 << (sz & 3'd3))) - 1) << (a[2:0]));
            xact(a, sz, strb, {$urandom, $urandom}, 1'b0, rd);
        end

        xact(64'h8000_0018, 3'd3, 8'hFF, 64'hCAFE_F00D_1234_5678, 1'b1, rd);
        xact(64'h8000_0018, 3'd3, 8'h00, 64'd0, 1'b0, rd);
        check("mutate_ld", rd, 64'hCAFE_F00D_1234_5678);
        xact(64'h8000_0100, 3'd3, 8'h00, 64'd0, 1'b0, rd);

        // LATENCY=1 responder: two requests with valid held throughout
        d1 = {$urandom, $urandom};
        @(negedge clk);
        bus_b.req.valid  = 1'b1;
        bus_b.req.addr   = BASE;
        bus_b.req.size   = 3'd3;
        bus_b.req.strobe = 8'hFF;
        bus_b.req.data   = d1;
        @(posedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("b2b_data_ok", bus_b.resp.data_ok, k == 1 || k == 3);
            check("b2b_busy", busy_b, k == 1 || k == 3);
            if (k == 1) begin
                bus_b.req.strobe = 8'h00;
                bus_b.req.data   = 64'd0;
            end
            if (k == 2 || k == 4) check("b2b_gap_data", bus_b.resp.data, 0);
            if (k == 3) begin
                check("b2b_ld", bus_b.resp.data, d1);
                bus_b.req.valid = 1'b0;
            end
        end
        $display("XACT b2b lat1 wdata=%h", d1);

        // Reset during the wait phase drops the store
        @(negedge clk);
        bus_a.req.valid  = 1'b1;
        bus_a.req.addr   = 64'h8000_0010;
        bus_a.req.size   = 3'd3;
        bus_a.req.strobe = 8'hFF;
        bus_a.req.data   = 64'hDEAD_BEEF_0000_0000;
        @(posedge clk);
        @(negedge clk);
        check("pre_reset_busy", busy_a, 1);
        rst_n = 1'b0;
        #1;
        check_quiet("midreset");
        bus_a.req.valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("reset_hold_data_ok", bus_a.resp.data_ok, 0);
        end
        rst_n   = 1'b1;
        exp_oor = 1'b0;
        $display("XACT aborted store addr=8000_0010 by reset");
        xact(64'h8000_0010, 3'd3, 8'h00, 64'd0, 1'b0, rd);
        check("post_reset_not_dead", rd == 64'hDEAD_BEEF_0000_0000, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
